// File: rtl/paver_pkg.sv
`default_nettype none
// ============================================================================
// paver_pkg
// Shared widths, text-word field positions and FSM encodings for the text
// RAM arbiter.
// Revision: 1.0
// ============================================================================
package paver_pkg;

    localparam int ADDR_W_DEF = 13;
    localparam int DATA_W_DEF = 32;

    // Text word layout: glyph code above an RGB565 colour.
    localparam int GLYPH_MSB  = 22;
    localparam int GLYPH_LSB  = 16;
    localparam int COLOUR_MSB = 15;
    localparam int COLOUR_LSB = 0;

    typedef enum logic [1:0] {
        C_IDLE   = 2'd0,
        C_ISSUE  = 2'd1,
        C_RDWAIT = 2'd2,
        C_ACK    = 2'd3
    } cpu_state_t;

    typedef enum logic [0:0] {
        F_IDLE = 1'b0,
        F_RUN  = 1'b1
    } fill_state_t;

endpackage : paver_pkg
`default_nettype wire

// File: rtl/paver_txt_arbiter_if.sv
`default_nettype none
// ============================================================================
// paver_txt_arbiter_if
// Display, CPU, fill-command and text-RAM signals of the arbiter.
// Revision: 1.0
// ============================================================================
interface paver_txt_arbiter_if
    import paver_pkg::*;
#(
    parameter int ADDR_W = ADDR_W_DEF,
    parameter int DATA_W = DATA_W_DEF
) ();

    logic              disp_req;
    logic [ADDR_W-1:0] disp_addr;
    logic [DATA_W-1:0] disp_q;
    logic              disp_valid;

    logic              cpu_req;
    logic              cpu_we;
    logic [ADDR_W-1:0] cpu_addr;
    logic [DATA_W-1:0] cpu_wdata;
    logic              cpu_ack;
    logic [DATA_W-1:0] cpu_rdata;

    logic              fill_start;
    logic [ADDR_W-1:0] fill_base;
    logic [ADDR_W:0]   fill_len;
    logic [DATA_W-1:0] fill_value;
    logic              fill_busy;
    logic              fill_done;

    logic [ADDR_W-1:0] txt_addr;
    logic [DATA_W-1:0] txt_data;
    logic              txt_wren;
    logic [DATA_W-1:0] txt_q;

    // Arbiter side.
    modport slave (
        input  disp_req, disp_addr,
        output disp_q, disp_valid,
        input  cpu_req, cpu_we, cpu_addr, cpu_wdata,
        output cpu_ack, cpu_rdata,
        input  fill_start, fill_base, fill_len, fill_value,
        output fill_busy, fill_done,
        output txt_addr, txt_data, txt_wren,
        input  txt_q
    );

    // Host / RAM side.
    modport master (
        output disp_req, disp_addr,
        input  disp_q, disp_valid,
        output cpu_req, cpu_we, cpu_addr, cpu_wdata,
        input  cpu_ack, cpu_rdata,
        output fill_start, fill_base, fill_len, fill_value,
        input  fill_busy, fill_done,
        input  txt_addr, txt_data, txt_wren,
        output txt_q
    );

endinterface : paver_txt_arbiter_if
`default_nettype wire

// File: rtl/paver_txt_fill.sv
`default_nettype none
// ============================================================================
// paver_txt_fill
// Block-fill engine: requests one RAM write per cycle until the count is spent.
// Revision: 1.0
// ============================================================================
module paver_txt_fill
    import paver_pkg::*;
#(
    parameter int ADDR_W = ADDR_W_DEF,
    parameter int DATA_W = DATA_W_DEF
) (
    input  wire logic              clk,
    input  wire logic              rst,
    input  wire logic              start,
    input  wire logic [ADDR_W-1:0] base,
    input  wire logic [ADDR_W:0]   len,
    input  wire logic [DATA_W-1:0] value,
    input  wire logic              gnt,
    output logic                   req,
    output logic [ADDR_W-1:0]      addr,
    output logic [DATA_W-1:0]      data,
    output logic                   busy,
    output logic                   done
);

    localparam logic [ADDR_W:0] LAST_ONE = {{ADDR_W{1'b0}}, 1'b1};

    fill_state_t     state;
    logic [ADDR_W:0] remaining;

    assign req = (state == F_RUN);

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= F_IDLE;
            addr      <= '0;
            data      <= '0;
            remaining <= '0;
            busy      <= 1'b0;
            done      <= 1'b0;
        end else begin
            done <= 1'b0;
            case (state)
                F_IDLE: begin
                    if (start) begin
                        addr      <= base;
                        data      <= value;
                        remaining <= len;
                        if (len == '0) begin
                            done <= 1'b1;
                        end else begin
                            state <= F_RUN;
                            busy  <= 1'b1;
                        end
                    end
                end
                F_RUN: begin
                    // Address is ADDR_W wide, so the increment wraps naturally.
                    if (gnt) begin
                        addr      <= addr + 1'b1;
                        remaining <= remaining - 1'b1;
                        if (remaining == LAST_ONE) begin
                            state <= F_IDLE;
                            busy  <= 1'b0;
                            done  <= 1'b1;
                        end
                    end
                end
                default: state <= F_IDLE;
            endcase
        end
    end

endmodule : paver_txt_fill
`default_nettype wire

// File: rtl/paver_txt_arbiter.sv
`default_nettype none
// ============================================================================
// paver_txt_arbiter
// Single-port text RAM arbiter: display > CPU > block fill, fixed priority.
// Revision: 1.0
// ============================================================================
module paver_txt_arbiter
    import paver_pkg::*;
#(
    parameter int ADDR_W = ADDR_W_DEF,
    parameter int DATA_W = DATA_W_DEF
) (
    input  wire logic          clk,
    input  wire logic          rst,
    paver_txt_arbiter_if.slave bus
);

    cpu_state_t        cpu_state;
    logic              cpu_we_l;
    logic [ADDR_W-1:0] cpu_addr_l;
    logic [DATA_W-1:0] cpu_wdata_l;
    logic              cpu_ack_r;
    logic [DATA_W-1:0] cpu_rdata_r;

    logic [ADDR_W-1:0] txt_addr_r;
    logic [DATA_W-1:0] txt_data_r;
    logic              txt_wren_r;

    logic              disp_p1;
    logic              disp_p2;
    logic              disp_valid_r;
    logic [DATA_W-1:0] disp_q_r;

    logic              fill_req;
    logic              fill_gnt;
    logic [ADDR_W-1:0] fill_addr;
    logic [DATA_W-1:0] fill_data;
    logic              fill_busy_w;
    logic              fill_done_w;

    logic              cpu_issue;
    logic              cpu_gnt;

    assign cpu_issue = (cpu_state == C_ISSUE);
    assign cpu_gnt   = cpu_issue && !bus.disp_req;
    assign fill_gnt  = fill_req && !bus.disp_req && !cpu_issue;

    paver_txt_fill #(
        .ADDR_W (ADDR_W),
        .DATA_W (DATA_W)
    ) u_fill (
        .clk   (clk),
        .rst   (rst),
        .start (bus.fill_start),
        .base  (bus.fill_base),
        .len   (bus.fill_len),
        .value (bus.fill_value),
        .gnt   (fill_gnt),
        .req   (fill_req),
        .addr  (fill_addr),
        .data  (fill_data),
        .busy  (fill_busy_w),
        .done  (fill_done_w)
    );

    // RAM port and display return pipeline (2-cycle read turnaround).
    always_ff @(posedge clk) begin
        if (rst) begin
            txt_addr_r   <= '0;
            txt_data_r   <= '0;
            txt_wren_r   <= 1'b0;
            disp_p1      <= 1'b0;
            disp_p2      <= 1'b0;
            disp_valid_r <= 1'b0;
            disp_q_r     <= '0;
        end else begin
            txt_wren_r   <= 1'b0;
            disp_p1      <= bus.disp_req;
            disp_p2      <= disp_p1;
            disp_valid_r <= disp_p2;
            if (disp_p2) begin
                disp_q_r <= bus.txt_q;
            end
            if (bus.disp_req) begin
                txt_addr_r <= bus.disp_addr;
            end else if (cpu_gnt) begin
                txt_addr_r <= cpu_addr_l;
                txt_data_r <= cpu_wdata_l;
                txt_wren_r <= cpu_we_l;
            end else if (fill_gnt) begin
                txt_addr_r <= fill_addr;
                txt_data_r <= fill_data;
                txt_wren_r <= 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cpu_state   <= C_IDLE;
            cpu_we_l    <= 1'b0;
            cpu_addr_l  <= '0;
            cpu_wdata_l <= '0;
            cpu_ack_r   <= 1'b0;
            cpu_rdata_r <= '0;
        end else begin
            cpu_ack_r <= 1'b0;
            case (cpu_state)
                C_IDLE: begin
                    // A request still held during the ack cycle is the old one.
                    if (bus.cpu_req && !cpu_ack_r) begin
                        cpu_we_l    <= bus.cpu_we;
                        cpu_addr_l  <= bus.cpu_addr;
                        cpu_wdata_l <= bus.cpu_wdata;
                        cpu_state   <= C_ISSUE;
                    end
                end
                C_ISSUE: begin
                    if (!bus.disp_req) begin
                        cpu_state <= cpu_we_l ? C_ACK : C_RDWAIT;
                    end
                end
                C_RDWAIT: cpu_state <= C_ACK;
                C_ACK: begin
                    cpu_ack_r <= 1'b1;
                    if (!cpu_we_l) begin
                        cpu_rdata_r <= bus.txt_q;
                    end
                    cpu_state <= C_IDLE;
                end
                default: cpu_state <= C_IDLE;
            endcase
        end
    end

    assign bus.txt_addr   = txt_addr_r;
    assign bus.txt_data   = txt_data_r;
    assign bus.txt_wren   = txt_wren_r;
    assign bus.disp_q     = disp_q_r;
    assign bus.disp_valid = disp_valid_r;
    assign bus.cpu_ack    = cpu_ack_r;
    assign bus.cpu_rdata  = cpu_rdata_r;
    assign bus.fill_busy  = fill_busy_w;
    assign bus.fill_done  = fill_done_w;

endmodule : paver_txt_arbiter
`default_nettype wire

// File: tb/tb_paver_txt_arbiter.sv
`default_nettype none
// ============================================================================
// tb_paver_txt_arbiter
// Table vectors, corner sequences and random traffic against a memory model.
// Revision: 1.0
// ============================================================================
module tb_paver_txt_arbiter;

    localparam int AW = 13;
    localparam int DW = 32;
    localparam int K_DISP = 0;
    localparam int K_WR   = 1;
    localparam int K_RD   = 2;
    localparam int NV     = 10;

    typedef struct {
        int          kind;
        logic [12:0] addr;
        logic [31:0] wdata;
        logic [31:0] exp_d;
        int          exp_lat;
    } vec_t;

    typedef struct {
        int          due;
        logic [31:0] d;
    } dexp_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    paver_txt_arbiter_if #(.ADDR_W(AW), .DATA_W(DW)) bus ();

    paver_txt_arbiter #(.ADDR_W(AW), .DATA_W(DW)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    logic [31:0] mem     [0:8191];
    logic [31:0] ref_mem [0:8191];
    bit          mem_ready = 1'b0;
    int          cyc = 0;
    int          n_chk = 0;
    int          n_pass = 0;
    int          wr_cnt = 0;
    int          fill_wr = 0;
    int          done_cnt = 0;
    int          ack_cnt = 0;
    bit          log_on = 1'b0;
    bit          mon_on = 1'b0;
    logic [12:0] wlog_a [$];
    logic [31:0] wlog_d [$];
    dexp_t       dq [$];
    dexp_t       mon_e;
    vec_t        tbl [NV];

    function automatic logic [31:0] init_word(input int a);
        logic [6:0]  g;
        logic [15:0] c;
        if (a == 32'h80) return 32'h0041_F800;
        g = 7'((a * 7 + 3) & 127);
        c = 16'((a * 40503 + 17) & 16'hFFFF);
        return {9'd0, g, c};
    endfunction

    // Text RAM: synchronous, one-cycle read latency, old data on write.
    always @(posedge clk) begin
        if (!mem_ready) begin
            for (int i = 0; i < 8192; i++) mem[i] = init_word(i);
            mem_ready = 1'b1;
        end
        cyc <= cyc + 1;
        bus.txt_q <= mem[bus.txt_addr];
        if (bus.txt_wren) begin
            mem[bus.txt_addr] = bus.txt_data;
            wr_cnt++;
            if (bus.txt_addr[12:8] == 5'h08) fill_wr++;
            if (log_on) begin
                wlog_a.push_back(bus.txt_addr);
                wlog_d.push_back(bus.txt_data);
            end
        end
        if (bus.fill_done) done_cnt++;
        if (bus.cpu_ack) ack_cnt++;
    end

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h, expected %0h", nm, act, exp);
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    // Display returns are matched against expectations queued at request time.
    always @(posedge clk) begin
        #1;
        if (mon_on) begin
            if (bus.disp_valid) begin
                if (dq.size() == 0) begin
                    chk("disp_unexpected", bus.disp_valid, 1'b0);
                end else begin
                    mon_e = dq.pop_front();
                    chk("disp_lat", cyc, mon_e.due);
                    chk("disp_q", bus.disp_q, mon_e.d);
                end
            end else if (dq.size() != 0 && dq[0].due <= cyc) begin
                chk("disp_valid_due", bus.disp_valid, 1'b1);
                mon_e = dq.pop_front();
            end
        end
    end

    task automatic cpu_txn(input logic we, input logic [12:0] a, input logic [31:0] d,
                           output logic [31:0] rd, output int lat);
        int k;
        lat = -1;
        rd  = '0;
        bus.cpu_req   = 1'b1;
        bus.cpu_we    = we;
        bus.cpu_addr  = a;
        bus.cpu_wdata = d;
        k = cyc;
        for (int t = 0; t < 200; t++) begin
            tick;
            if (bus.cpu_ack) begin
                lat = cyc - (k + 1);
                rd  = bus.cpu_rdata;
                break;
            end
        end
        bus.cpu_req = 1'b0;
        if (we && lat >= 0) ref_mem[a] = d;
    endtask

    task automatic do_fill(input logic [12:0] base, input logic [13:0] len, input logic [31:0] val);
        bit          seen;
        int          bad;
        logic [12:0] a;
        bus.fill_base  = base;
        bus.fill_len   = len;
        bus.fill_value = val;
        bus.fill_start = 1'b1;
        tick;
        bus.fill_start = 1'b0;
        chk("fill_busy_after_start", bus.fill_busy, (len != 0));
        seen = 1'b0;
        for (int t = 0; t < 400; t++) begin
            if (bus.fill_done) begin
                seen = 1'b1;
                break;
            end
            tick;
        end
        chk("fill_done_seen", seen, 1'b1);
        tick;
        chk("fill_busy_after_done", bus.fill_busy, 1'b0);
        bad = 0;
        for (int i = 0; i < int'(len); i++) begin
            a = base + 13'(i);
            if (mem[a] !== val) bad++;
            ref_mem[a] = val;
        end
        chk("fill_contents_bad", bad, 0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $display("%0d/%0d checks passed", n_pass, n_chk + 1);
        $fatal(1, "watchdog");
    end

    initial begin
        int          k;
        int          lat;
        int          ack0;
        int          done0;
        int          wr0;
        int          ack_at;
        logic [31:0] rd;
        logic [31:0] got;

        tbl[0] = '{K_DISP, 13'h0080, 32'h0,         32'h0041_F800, 2};
        tbl[1] = '{K_WR,   13'h1FFF, 32'h1234_5678, 32'h1234_5678, 2};
        tbl[2] = '{K_RD,   13'h1FFF, 32'h0,         32'h1234_5678, 3};
        tbl[3] = '{K_WR,   13'h0A00, 32'hDEAD_BEEF, 32'hDEAD_BEEF, 2};
        tbl[4] = '{K_RD,   13'h0A00, 32'h0,         32'hDEAD_BEEF, 3};
        tbl[5] = '{K_DISP, 13'h0001, 32'h0,         init_word(1),  2};
        tbl[6] = '{K_RD,   13'h0080, 32'h0,         32'h0041_F800, 3};
        tbl[7] = '{K_WR,   13'h0A00, 32'h0,         32'h0,         2};
        tbl[8] = '{K_RD,   13'h0A00, 32'h0,         32'h0,         3};
        tbl[9] = '{K_DISP, 13'h00FF, 32'h0,         init_word(255), 2};

        for (int i = 0; i < 8192; i++) ref_mem[i] = init_word(i);
        bus.disp_req = 1'b0;   bus.disp_addr = '0;
        bus.cpu_req = 1'b0;    bus.cpu_we = 1'b0; bus.cpu_addr = '0; bus.cpu_wdata = '0;
        bus.fill_start = 1'b0; bus.fill_base = '0; bus.fill_len = '0; bus.fill_value = '0;

        // Reset state
        tick; tick; tick;
        chk("rst_txt_wren", bus.txt_wren, 1'b0);
        chk("rst_disp_valid", bus.disp_valid, 1'b0);
        chk("rst_cpu_ack", bus.cpu_ack, 1'b0);
        chk("rst_fill_busy", bus.fill_busy, 1'b0);
        chk("rst_fill_done", bus.fill_done, 1'b0);
        chk("rst_txt_addr", bus.txt_addr, 13'h0);
        chk("rst_disp_q", bus.disp_q, 32'h0);
        chk("rst_cpu_rdata", bus.cpu_rdata, 32'h0);
        rst = 1'b0;
        tick; tick;

        // Table vectors
        for (int i = 0; i < NV; i++) begin
            if (tbl[i].kind == K_DISP) begin
                bus.disp_req  = 1'b1;
                bus.disp_addr = tbl[i].addr;
                k = cyc;
                tick;
                bus.disp_req = 1'b0;
                lat = -1;
                got = '0;
                for (int t = 0; t < 8; t++) begin
                    if (bus.disp_valid) begin
                        lat = cyc - (k + 1);
                        got = bus.disp_q;
                        break;
                    end
                    tick;
                end
                chk($sformatf("vec%0d_disp_lat", i), lat, tbl[i].exp_lat);
                chk($sformatf("vec%0d_disp_q", i), got, tbl[i].exp_d);
            end else begin
                cpu_txn(tbl[i].kind == K_WR, tbl[i].addr, tbl[i].wdata, rd, lat);
                chk($sformatf("vec%0d_ack_lat", i), lat, tbl[i].exp_lat);
                if (tbl[i].kind == K_WR) chk($sformatf("vec%0d_ram", i), mem[tbl[i].addr], tbl[i].exp_d);
                else chk($sformatf("vec%0d_rdata", i), rd, tbl[i].exp_d);
            end
            tick; tick;
        end

        // Display held 5 cycles while a CPU write waits
        mon_on = 1'b1;
        wr0 = wr_cnt;
        bus.cpu_req = 1'b1; bus.cpu_we = 1'b1; bus.cpu_addr = 13'h0B00; bus.cpu_wdata = 32'hCAFE_F00D;
        k = cyc;
        for (int j = 0; j < 5; j++) begin
            bus.disp_req  = 1'b1;
            bus.disp_addr = 13'(16 + j);
            mon_e.due = cyc + 3;
            mon_e.d   = ref_mem[16 + j];
            dq.push_back(mon_e);
            tick;
            chk("hold_no_ack", bus.cpu_ack, 1'b0);
        end
        bus.disp_req = 1'b0;
        ack_at = -1;
        for (int t = 0; t < 20; t++) begin
            tick;
            if (bus.cpu_ack) begin
                ack_at = cyc;
                break;
            end
        end
        bus.cpu_req = 1'b0;
        chk("hold_ack_cycle", ack_at, k + 7);
        chk("hold_one_write", wr_cnt - wr0, 1);
        ref_mem[13'h0B00] = 32'hCAFE_F00D;
        tick; tick; tick;
        chk("hold_disp_drained", dq.size(), 0);
        mon_on = 1'b0;

        // Wrapping fill
        wlog_a.delete(); wlog_d.delete();
        log_on = 1'b1;
        done0 = done_cnt;
        do_fill(13'h1FFE, 14'd4, 32'h20);
        tick; tick;
        log_on = 1'b0;
        chk("wrap_nwrites", wlog_a.size(), 4);
        if (wlog_a.size() == 4) begin
            chk("wrap_a0", wlog_a[0], 13'h1FFE);
            chk("wrap_a1", wlog_a[1], 13'h1FFF);
            chk("wrap_a2", wlog_a[2], 13'h0000);
            chk("wrap_a3", wlog_a[3], 13'h0001);
            chk("wrap_d3", wlog_d[3], 32'h20);
        end
        chk("wrap_done_pulses", done_cnt - done0, 1);

        // Zero-length fill, then start ignored while busy
        wr0 = wr_cnt;
        bus.fill_base = 13'h0300; bus.fill_len = '0; bus.fill_value = 32'h99;
        bus.fill_start = 1'b1;
        tick;
        bus.fill_start = 1'b0;
        chk("len0_done", bus.fill_done, 1'b1);
        chk("len0_busy", bus.fill_busy, 1'b0);
        tick;
        chk("len0_done_once", bus.fill_done, 1'b0);
        chk("len0_no_writes", wr_cnt - wr0, 0);
        wr0 = wr_cnt;
        done0 = done_cnt;
        bus.fill_base = 13'h0400; bus.fill_len = 14'd8; bus.fill_value = 32'h55;
        bus.fill_start = 1'b1;
        tick;
        bus.fill_base = 13'h0600; bus.fill_len = 14'd2; bus.fill_value = 32'h66;
        tick; tick;
        bus.fill_start = 1'b0;
        for (int t = 0; t < 30; t++) tick;
        chk("busy_restart_writes", wr_cnt - wr0, 8);
        chk("busy_restart_done", done_cnt - done0, 1);
        chk("busy_restart_untouched", mem[13'h0600], ref_mem[13'h0600]);
        chk("busy_restart_last", mem[13'h0407], 32'h55);
        for (int i = 0; i < 8; i++) ref_mem[13'h0400 + i] = 32'h55;

        // Reset in the middle of a fill and a CPU read
        wlog_a.delete(); wlog_d.delete();
        log_on = 1'b1;
        bus.fill_base = 13'h0300; bus.fill_len = 14'd8; bus.fill_value = 32'h77;
        bus.fill_start = 1'b1;
        tick;
        bus.fill_start = 1'b0;
        for (int t = 0; t < 50; t++) begin
            if (wlog_a.size() >= 3) break;
            tick;
        end
        chk("midrst_progress", wlog_a.size(), 3);
        bus.cpu_req = 1'b1; bus.cpu_we = 1'b0; bus.cpu_addr = 13'h1FFF;
        tick; tick;
        ack0 = ack_cnt;
        done0 = done_cnt;
        rst = 1'b1;
        tick;
        bus.cpu_req = 1'b0;
        chk("midrst_txt_wren", bus.txt_wren, 1'b0);
        chk("midrst_fill_busy", bus.fill_busy, 1'b0);
        chk("midrst_txt_addr", bus.txt_addr, 13'h0);
        chk("midrst_txt_data", bus.txt_data, 32'h0);
        chk("midrst_cpu_rdata", bus.cpu_rdata, 32'h0);
        chk("midrst_disp_q", bus.disp_q, 32'h0);
        tick;
        rst = 1'b0;
        log_on = 1'b0;
        wr0 = wr_cnt;
        for (int t = 0; t < 8; t++) tick;
        chk("midrst_no_ack", ack_cnt - ack0, 0);
        chk("midrst_no_done", done_cnt - done0, 0);
        chk("midrst_no_writes", wr_cnt - wr0, 0);
        chk("midrst_busy_low", bus.fill_busy, 1'b0);
        cpu_txn(1'b1, 13'h0B01, 32'h0BAD_F00D, rd, lat);
        chk("midrst_cpu_idle_lat", lat, 2);

        // Random traffic: display reads 0x000-0x0FF, CPU 0x1000-0x103F, fills 0x08xx
        mon_on = 1'b1;
        fork
            begin : p_disp
                logic [7:0] da;
                dexp_t      de;
                for (int i = 0; i < 600; i++) begin
                    if ($urandom_range(3) == 0) begin
                        da = 8'($urandom_range(255));
                        bus.disp_req  = 1'b1;
                        bus.disp_addr = {5'd0, da};
                        de.due = cyc + 3;
                        de.d   = ref_mem[{5'd0, da}];
                        dq.push_back(de);
                    end else begin
                        bus.disp_req = 1'b0;
                    end
                    tick;
                end
                bus.disp_req = 1'b0;
            end
            begin : p_cpu
                logic [12:0] ca;
                logic [31:0] cd;
                logic [31:0] crd;
                logic        cwe;
                int          clat;
                for (int i = 0; i < 60; i++) begin
                    ca  = 13'h1000 + 13'($urandom_range(63));
                    cd  = $urandom;
                    cwe = 1'($urandom_range(1));
                    cpu_txn(cwe, ca, cd, crd, clat);
                    chk("rnd_cpu_ack_seen", (clat >= 0), 1'b1);
                    chk("rnd_cpu_lat_min", (clat >= (cwe ? 2 : 3)), 1'b1);
                    if (!cwe) chk("rnd_cpu_rdata", crd, ref_mem[ca]);
                    repeat ($urandom_range(3)) tick;
                end
            end
            begin : p_fill
                int f0;
                int flen;
                for (int i = 0; i < 6; i++) begin
                    repeat ($urandom_range(20)) tick;
                    flen = 1 + $urandom_range(15);
                    f0 = fill_wr;
                    do_fill(13'h0800 + 13'($urandom_range(200)), 14'(flen), $urandom);
                    chk("rnd_fill_writes", fill_wr - f0, flen);
                end
            end
        join
        tick; tick; tick; tick;
        chk("rnd_disp_drained", dq.size(), 0);
        mon_on = 1'b0;

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule : tb_paver_txt_arbiter
`default_nettype wire

// File: doc/paver_txt_arbiter.md
PAVER_TXT_ARBITER -- requirements
Module: paver_txt_arbiter

Interface
REQ-001 SHALL have parameter ADDR_W, default 13, text RAM word-address width.
REQ-002 SHALL have parameter DATA_W, default 32, text RAM word width: glyph in [22:16], RGB565 colour in [15:0].
REQ-003 SHALL have port clk  in  1  sole clock; all logic on posedge.
REQ-004 SHALL have port rst  in  1  synchronous, active-high reset.
REQ-005 SHALL have ports disp_req in 1 / disp_addr in ADDR_W: display glyph-fetch strobe and address.
REQ-006 SHALL have ports disp_q out DATA_W / disp_valid out 1: fetched word and its one-cycle qualifier.
REQ-007 SHALL have ports cpu_req in 1, cpu_we in 1, cpu_addr in ADDR_W, cpu_wdata in DATA_W: CPU access request.
REQ-008 SHALL have ports cpu_ack out 1 / cpu_rdata out DATA_W: one-cycle completion pulse and read data.
REQ-009 SHALL have ports fill_start in 1, fill_base in ADDR_W, fill_len in ADDR_W+1, fill_value in DATA_W: block-fill command, e.g. clear screen.
REQ-010 SHALL have ports fill_busy out 1 / fill_done out 1: fill engine active; one-cycle completion pulse.
REQ-011 SHALL have ports txt_addr out ADDR_W, txt_data out DATA_W, txt_wren out 1, txt_q in DATA_W to the single-port synchronous text RAM, which has 1-cycle read latency.

Function
REQ-012 SHALL arbitrate every cycle with fixed priority: display > CPU > fill.
REQ-013 SHALL register txt_addr, txt_data and txt_wren at the posedge that grants an access (edge N).
REQ-014 SHALL capture txt_q at edge N+2 for a display grant into disp_q, with disp_valid high for that one cycle.
REQ-015 SHALL implement the CPU FSM states C_IDLE, C_ISSUE, C_RDWAIT, C_ACK.
REQ-016 SHALL move C_IDLE->C_ISSUE on cpu_req=1.
REQ-017 SHALL move C_ISSUE->C_ACK on grant when cpu_we=1, or C_ISSUE->C_RDWAIT when cpu_we=0, staying in C_ISSUE while the display wins.
REQ-018 SHALL move C_RDWAIT->C_ACK after one cycle, and C_ACK->C_IDLE unconditionally.
REQ-019 SHALL latch cpu_we, cpu_addr and cpu_wdata on leaving C_IDLE; the CPU holds cpu_req until cpu_ack.
REQ-020 SHALL pulse cpu_ack one cycle at edge N+1 for a write, or at edge N+2 for a read with cpu_rdata=txt_q valid in that same cycle.
REQ-021 SHALL not re-enter C_ISSUE in the cycle of cpu_ack, giving a minimum 3-cycle CPU cadence.
REQ-022 SHALL implement the fill FSM states F_IDLE and F_RUN.
REQ-023 SHALL, on fill_start in F_IDLE, latch base, remaining count=fill_len and value, and raise fill_busy.
REQ-024 SHALL, in F_RUN, write fill_value to the current address on each cycle lost by both display and CPU, then increment the address and decrement the count.
REQ-025 SHALL wrap the fill address modulo 2^ADDR_W.
REQ-026 SHALL leave F_RUN after the write that makes the count 0, drop fill_busy and pulse fill_done once in the next cycle.
REQ-027 SHALL treat fill_len=0 as no RAM writes, with fill_done pulsing in the cycle after fill_start.
REQ-028 SHALL ignore fill_start while fill_busy=1.
REQ-029 SHALL let a CPU access interleave with a fill and carry out no ordering or hazard checks; a later fill write may overwrite a CPU write.
REQ-030 SHALL drive txt_wren=0 and hold the previous txt_addr in idle cycles.
REQ-031 SHALL make display data unaffected by CPU or fill activity, with fixed 2-cycle latency.

Reset
REQ-032 SHALL, while rst=1, hold txt_wren, disp_valid, cpu_ack, fill_busy and fill_done at 0, and txt_addr, txt_data, disp_q and cpu_rdata at 0.
REQ-033 SHALL, on rst, force both FSMs to their idle states from any state.
REQ-034 SHALL discard any fill or CPU transaction in progress at reset, with no ack or done pulse.

Structure
REQ-035 SHALL place ADDR_W/DATA_W defaults, the CPU and fill state encodings and the glyph/colour field positions in shared package paver_pkg.
REQ-036 SHALL implement the fill engine as sub-module paver_txt_fill, with a request/grant interface to the arbiter core.

Verification
REQ-037 SHALL cover: disp_req pulses at addr 0x0080 with RAM[0x0080]=0x0041F800 -> disp_q=0x0041F800 and disp_valid exactly 2 cycles later.
REQ-038 SHALL cover: CPU write 0x12345678 to 0x1FFF, then read -> write ack at N+1, then cpu_rdata=0x12345678 with ack at N+2.
REQ-039 SHALL cover: disp_req held high 5 cycles while cpu_req is pending -> no CPU grant during them; cpu_ack 1 cycle after display releases (write).
REQ-040 SHALL cover: fill base=0x1FFE, len=4, value=0x20 -> addresses 0x1FFE, 0x1FFF, 0x0000, 0x0001 written, then one fill_done pulse.
REQ-041 SHALL cover: fill_len=0, and fill_start re-asserted while busy -> no writes; done next cycle; second start ignored.
REQ-042 SHALL cover: rst asserted mid-fill (3 of 8 written) and mid CPU read -> outputs 0, no ack or done, FSMs idle next cycle.
